// File: rtl/stack_param.sv
// rtl/stack_param.sv - parametrised LIFO stack with registered pop data and sticky error flags
module stack_param #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    parameter  int AF_LEVEL   = DEPTH - 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  err_clr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  we;
    logic [AW-1:0]         widx;
    logic [AW-1:0]         push_idx;
    logic [AW-1:0]         top_idx;
    logic [CW-1:0]         count_m1;

    assign count_m1 = count_q - CW'(1);
    assign push_idx = AW'(count_q);
    assign top_idx  = AW'(count_m1);

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = (count_q >= CW'(AF_LEVEL));

    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q & ~err_clr;
        unf_d   = unf_q & ~err_clr;
        we      = 1'b0;
        widx    = push_idx;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    we      = 1'b1;
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    rd_d    = mem_q[top_idx];
                    count_d = count_m1;
                end else begin
                    unf_d = 1'b1;
                end
            end
            2'b11: begin
                // Replace the top in place; on an empty stack the push data bypasses storage.
                if (!empty) begin
                    rd_d = mem_q[top_idx];
                    we   = 1'b1;
                    widx = top_idx;
                end else begin
                    rd_d = write_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= write_data;
        end
    end

    assign read_data = rd_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_param.sv
// tb/tb_stack_param.sv - directed self-checking bench for stack_param
module tb_stack_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_push, a_pop, a_clr;
    logic [7:0] a_wd, a_rd;
    logic       a_empty, a_full, a_af, a_ovf, a_unf;
    logic [2:0] a_cnt;

    logic        b_rst, b_push, b_pop, b_clr;
    logic [15:0] b_wd, b_rd;
    logic        b_empty, b_full, b_af, b_ovf, b_unf;
    logic [2:0]  b_cnt;

    stack_param #(.DATA_WIDTH(8), .DEPTH(4)) u_a (
        .clk(clk), .rst(a_rst), .push(a_push), .pop(a_pop), .err_clr(a_clr),
        .write_data(a_wd), .read_data(a_rd), .empty(a_empty), .full(a_full),
        .almost_full(a_af), .count(a_cnt), .overflow(a_ovf), .underflow(a_unf)
    );

    stack_param #(.DATA_WIDTH(16), .DEPTH(5)) u_b (
        .clk(clk), .rst(b_rst), .push(b_push), .pop(b_pop), .err_clr(b_clr),
        .write_data(b_wd), .read_data(b_rd), .empty(b_empty), .full(b_full),
        .almost_full(b_af), .count(b_cnt), .overflow(b_ovf), .underflow(b_unf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic op_a(input logic ps, input logic pp, input logic clr, input logic [7:0] d);
        a_push = ps; a_pop = pp; a_clr = clr; a_wd = d;
        @(posedge clk); #1;
        a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0;
    endtask

    task automatic op_b(input logic ps, input logic pp, input logic [15:0] d);
        b_push = ps; b_pop = pp; b_wd = d;
        @(posedge clk); #1;
        b_push = 1'b0; b_pop = 1'b0;
    endtask

    initial begin
        a_rst = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_wd = '0;
        b_rst = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_wd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("a_rst_rd",    a_rd,    0);
        check("a_rst_cnt",   a_cnt,   0);
        check("a_rst_empty", a_empty, 1);
        check("a_rst_full",  a_full,  0);
        check("a_rst_af",    a_af,    0);
        check("a_rst_ovf",   a_ovf,   0);
        check("a_rst_unf",   a_unf,   0);
        #2 a_rst = 1'b1; b_rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 1; i <= 4; i++) begin
            op_a(1, 0, 0, 8'(i));
            check($sformatf("a_push_cnt%0d", i), a_cnt, i);
            check($sformatf("a_push_af%0d", i), a_af, (i >= 3) ? 1 : 0);
            check($sformatf("a_push_full%0d", i), a_full, (i == 4) ? 1 : 0);
        end
        for (int i = 4; i >= 1; i--) begin
            op_a(0, 1, 0, 8'h00);
            check($sformatf("a_pop_rd%0d", i), a_rd, i);
            check($sformatf("a_pop_cnt%0d", i), a_cnt, i - 1);
        end
        check("a_pop_empty", a_empty, 1);
        check("a_pop_unf", a_unf, 0);

        for (int i = 1; i <= 4; i++) op_a(1, 0, 0, 8'(i));
        op_a(1, 0, 0, 8'h55);
        check("a_ovf_cnt", a_cnt, 4);
        check("a_ovf_set", a_ovf, 1);
        check("a_ovf_full", a_full, 1);
        op_a(0, 0, 1, 8'h00);
        check("a_ovf_clr", a_ovf, 0);
        for (int i = 4; i >= 1; i--) begin
            op_a(0, 1, 0, 8'h00);
            check($sformatf("a_ovf_pop%0d", i), a_rd, i);
        end

        op_a(0, 1, 0, 8'h00);
        check("a_unf_set", a_unf, 1);
        check("a_unf_rd", a_rd, 1);
        check("a_unf_cnt", a_cnt, 0);
        op_a(0, 1, 1, 8'h00);
        check("a_unf_setwins", a_unf, 1);
        op_a(0, 0, 1, 8'h00);
        check("a_unf_clr", a_unf, 0);

        op_a(1, 0, 0, 8'd1);
        op_a(1, 0, 0, 8'd2);
        op_a(1, 1, 0, 8'd9);
        check("a_repl_rd", a_rd, 2);
        check("a_repl_cnt", a_cnt, 2);
        op_a(0, 1, 0, 8'h00);
        check("a_repl_pop9", a_rd, 9);
        op_a(0, 1, 0, 8'h00);
        check("a_repl_pop1", a_rd, 1);
        check("a_repl_empty", a_empty, 1);

        op_a(1, 1, 0, 8'hA5);
        check("a_byp_rd", a_rd, 8'hA5);
        check("a_byp_cnt", a_cnt, 0);
        check("a_byp_empty", a_empty, 1);
        check("a_byp_ovf", a_ovf, 0);
        check("a_byp_unf", a_unf, 0);

        for (int i = 1; i <= 5; i++) begin
            op_b(1, 0, 16'h1000 + 16'(i));
            check($sformatf("b_push_cnt%0d", i), b_cnt, i);
            check($sformatf("b_push_af%0d", i), b_af, (i >= 4) ? 1 : 0);
            check($sformatf("b_push_full%0d", i), b_full, (i == 5) ? 1 : 0);
        end
        op_b(1, 0, 16'hBEEF);
        check("b_ovf_set", b_ovf, 1);
        check("b_ovf_cnt", b_cnt, 5);
        op_b(0, 1, 16'h0000);
        check("b_pop_rd", b_rd, 16'h1005);
        check("b_pop_cnt", b_cnt, 4);

        b_push = 1'b1; b_wd = 16'h7777;
        @(posedge clk); #3;
        b_rst = 1'b0;
        #1;
        check("b_arst_cnt",   b_cnt,   0);
        check("b_arst_rd",    b_rd,    0);
        check("b_arst_empty", b_empty, 1);
        check("b_arst_full",  b_full,  0);
        check("b_arst_af",    b_af,    0);
        check("b_arst_ovf",   b_ovf,   0);
        @(posedge clk); #1;
        check("b_rsthold_cnt", b_cnt, 0);
        b_push = 1'b0;
        b_rst = 1'b1;
        @(posedge clk); #1;
        op_b(0, 1, 16'h0000);
        check("b_post_unf", b_unf, 1);
        check("b_post_rd", b_rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_param.md
# stack_param

Parametrised LIFO stack with registered pop data, occupancy count, almost-full flag and sticky overflow/underflow error flags. It is the next-generation replacement for the fixed 8-bit, 4-entry stack and is generalised in width and depth. It adds same-cycle push+pop (replace/bypass) and error reporting. Sits between a producer and consumer in the chapter 7 datapath examples; one clock domain.

## Interface
- DATA_WIDTH, 8, width of write_data/read_data
- DEPTH, 4, number of entries; any integer >= 2 (not restricted to powers of two)
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
- CW (localparam), $clog2(DEPTH+1), width of count
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- push  input  1  write request
- pop  input  1  read request
- err_clr  input  1  synchronous clear of overflow/underflow
- write_data  input  DATA_WIDTH  data to push
- read_data  output  DATA_WIDTH  registered data of last successful pop
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_full  output  1  count >= AF_LEVEL
- count  output  CW  current occupancy, 0..DEPTH
- overflow  output  1  sticky: push attempted while full without pop
- underflow  output  1  sticky: pop attempted while empty without push

## Operation
- Storage: DEPTH x DATA_WIDTH register array, no reset on contents; stack pointer sp = count; top entry is mem[sp-1].
- Per-edge action decoded from {push, pop} and state:
- push only, not full: mem[sp] <= write_data; count+1; read_data holds.
- push only, full: no write, count holds; overflow <= 1.
- pop only, not empty: read_data <= mem[sp-1]; count-1.
- pop only, empty: read_data holds, count holds; underflow <= 1.
- push+pop, not empty (including full): replace; read_data <= mem[sp-1] (old top), mem[sp-1] <= write_data, count unchanged; no error.
- push+pop, empty: bypass; read_data <= write_data, count stays 0, no write; no error.
- neither: all state holds.
- err_clr: clears overflow and underflow; if an error event occurs in the same cycle, set wins.
- empty, full, almost_full are derived from the registered count (combinational decode of count only, no path from push/pop).
- count arithmetic saturates by construction: never exceeds DEPTH, never wraps below 0.

## Timing
- Reset (rst low, asynchronous assert, synchronous-effect release on next edge): read_data=0, count=0, empty=1, full=0, almost_full=0 (1 only if AF_LEVEL would be 0, which is illegal), overflow=0, underflow=0.
- Inputs sampled on the rising edge; all outputs valid after that same edge (latency 1 cycle from request to read_data/count/flags).
- read_data is never combinational from mem; consumer samples it the cycle after the pop edge.
- Back-to-back push or pop every cycle is supported at full rate; no bubbles.
- Reset asserted mid-burst discards all contents immediately; pushes/pops during rst low are ignored.

## Test plan
- Reset then push 1,2,3,4 (DEPTH=4, W=8) on 4 edges -> count 1..4, full=1 after 4th, almost_full=1 from 3rd; pop 4x -> read_data 4,3,2,1, empty=1 after last.
- Full stack, push 8'h55 alone -> count stays 4, overflow=1, contents unchanged (subsequent pops return 4,3,2,1); assert err_clr -> overflow=0 next edge.
- Empty stack, pop alone -> underflow=1, read_data holds previous value, count=0; err_clr and pop same cycle -> underflow stays 1.
- Stack holding 1,2; push+pop with write_data=9 -> read_data=2, count=2; next pop -> read_data=9, then pop -> 1.
- Empty stack, push+pop with write_data=8'hA5 -> read_data=A5, count=0, empty=1, no error flags.
- DEPTH=5, DATA_WIDTH=16: push 5 then push again -> full at 5, overflow set; pull rst low mid-sequence -> all outputs to reset values asynchronously, before next clk edge.
